// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory arbiter state encoding and requester port indices.
// Pure declarations; no latency or flow control of its own.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_arb_state_e;

  localparam int PORT_CU = 0;
  localparam int PORT_LD = 1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: one-hot winner, zero when nothing requests.
// Zero latency; no backpressure, the caller decides when to act on the result.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req == 2'b11) begin
      // Contention goes to whichever port was not served last.
      win[PORT_CU] = last;
      win[PORT_LD] = ~last;
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin owner of the single-port dmem; req -> ack takes MEM_LAT+1 cycles, one access in flight.
// Requesters hold req until ack; optional grant locking under DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int ADDR_W    = 8,
  parameter int MEM_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [2*ADDR_W-1:0]    addr,
  input  logic [2*BUS_WIDTH-1:0] wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [1:0]             lock,
`endif
  output logic [1:0]             gnt,
  output logic [1:0]             ack,
  output logic [BUS_WIDTH-1:0]   rdata,
  output logic                   busy,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [BUS_WIDTH-1:0]   mem_wdata,
  input  logic [BUS_WIDTH-1:0]   mem_rdata
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("dmem_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  dmem_arb_state_e state_q, state_d;
  logic [3:0]           cnt_q;
  logic                 win_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [BUS_WIDTH-1:0] rdata_q;
  logic                 rr_last_q;
  logic [1:0]           pick_win;
  logic [1:0]           sel_win;
  logic                 sel_port;
  logic [1:0]           win_oh;
  logic                 last_cyc;

  rr_pick2 u_pick (
    .req  (req),
    .last (rr_last_q),
    .win  (pick_win)
  );

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q;
  // A locked owner keeps the memory as long as it keeps asking for it.
  assign sel_win = (lock_q && req[win_q]) ? (win_q ? 2'b10 : 2'b01) : pick_win;
`else
  assign sel_win = pick_win;
`endif

  assign sel_port = sel_win[PORT_LD];
  assign win_oh   = win_q ? 2'b10 : 2'b01;
  assign last_cyc = (cnt_q == 4'(MEM_LAT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|sel_win) state_d = ACCESS;
      ACCESS:  if (last_cyc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt       = (state_q != IDLE) ? win_oh : 2'b00;
    ack       = (state_q == DONE) ? win_oh : 2'b00;
    busy      = (state_q != IDLE);
    mem_en    = (state_q == ACCESS);
    mem_we    = mem_en & we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    rdata     = rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rr_last_q <= 1'b1;
`ifdef DMEM_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (|sel_win) begin
            win_q   <= sel_port;
            we_q    <= we[sel_port];
            addr_q  <= sel_port ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            wdata_q <= sel_port ? wdata[2*BUS_WIDTH-1:BUS_WIDTH] : wdata[BUS_WIDTH-1:0];
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (last_cyc && !we_q) rdata_q <= mem_rdata;
        end
        DONE: begin
`ifdef DMEM_ARB_LOCK_EN
          lock_q <= lock[win_q];
          if (!lock[win_q]) rr_last_q <= win_q;
`else
          rr_last_q <= win_q;
`endif
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule
